mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Parametrised multicycle RV32I control FSM. Sequences fetch/decode/execute/writeback
//  and drives the datapath muxes and enables. Adds over the previous control unit:
//  - mem_ready handshake with stall on every memory state
//  - stall timeout with bus_error pulse
//  - SYSTEM-opcode halt
//  - optional illegal-opcode trap
//  Sits between the instruction register (opcode) and the multicycle datapath/memory port.
// PARAMETERS
//  TIMEOUT_W  8   width of the stall-wait counter
//  TIMEOUT    200 max stall cycles in a memory state before abort; 0 = wait forever
//  OPC_W      7   opcode width (RV32I = 7)
// PORTS
//  clk                 in  1       clock, rising edge
//  rst_n               in  1       reset, asynchronous, active-low
//  instruction_opcode  in  OPC_W   opcode from the IR
//  mem_ready           in  1       memory access completes this cycle
//  pc_write, ir_write, pc_write_cond, reg_write  out 1  datapath write enables
//  memory_read, memory_write, lorD               out 1  memory port controls; lorD 1 = ALUOut address
//  memory_to_reg, is_immediate                   out 1  writeback select 1 = MDR; I-type ALU decode
//  pc_source           out 2  00 = ALU, 01 = ALUOut, 10 = trap vector
//  aluop               out 2  00 = add, 01 = branch compare, 10 = funct decode
//  alu_src_a           out 2  00 = PC, 01 = rs1, 10 = oldPC, 11 = zero
//  alu_src_b           out 2  00 = rs2, 01 = 4, 10 = imm
//  bus_error           out 1  1-cycle pulse on stall timeout
//  halted              out 1  level; set in HALT
//  trap                out 1  1-cycle pulse in TRAP (0 when the trap feature is compiled out)
//  state_o             out 5  current state, for debug
// BEHAVIOUR
//  Reset:
//  - state = FETCH, wait counter = 0
//  - all outputs combinational from state except bus_error, which is registered
//  - while rst_n is low, every output is 0 except state_o = FETCH
//  Memory states (FETCH, MEMREAD, MEMWRITE):
//  - memory_read or memory_write is held every cycle until mem_ready = 1
//  - ir_write/pc_write (FETCH) and the MDR capture happen only in the mem_ready cycle
//  - state advances on the cycle after mem_ready; minimum latency is 1 cycle per memory state
//  - the wait counter increments each stalled cycle and clears on leaving the state
//  - if TIMEOUT != 0 and the counter reaches TIMEOUT: bus_error pulses 1 cycle,
//    the access is dropped (no writes) and the FSM goes to FETCH
//  - mem_ready in the same cycle as the timeout: mem_ready wins
//  States, transitions and asserted outputs (unlisted outputs = 0):
//  - FETCH: mem_read, src_a 00, src_b 01; on mem_ready also ir_write, pc_write -> DECODE
//  - DECODE: src_a 10, src_b 10 (branch target). Next state by opcode:
//    LW/SW -> MEMADR; R -> EXECR; I -> EXECI; JAL -> JAL; JALR -> JALR_ADDR;
//    BRANCH -> BRANCH; AUIPC -> AUIPC; LUI -> LUI; SYSTEM (1110011) -> HALT; other -> ILLEGAL
//  - MEMADR: src_a 01, src_b 10 -> MEMREAD (LW) or MEMWRITE (SW)
//  - MEMREAD: memory_read, lorD -> MEMWB
//  - MEMWB: reg_write, memory_to_reg -> FETCH
//  - MEMWRITE: memory_write, lorD -> FETCH
//  - EXECR: src_a 01, src_b 00, aluop 10 -> ALUWB
//  - EXECI: as EXECR with src_b 10, is_immediate -> ALUWB
//  - JAL: src_a 10, src_b 01, pc_write, pc_source 01 -> ALUWB
//  - JALR_ADDR: src_a 01, src_b 10 -> JALR
//  - JALR: src_a 10, src_b 01, pc_write, pc_source 01 -> ALUWB
//  - BRANCH: src_a 01, src_b 00, aluop 01, pc_write_cond, pc_source 01 -> FETCH
//  - AUIPC: src_a 10, src_b 10 -> ALUWB
//  - LUI: src_a 11, src_b 10 -> ALUWB
//  - ALUWB: reg_write -> FETCH
//  - HALT: halted = 1, no enables; stays until rst_n
//  - ILLEGAL: see CONFIGURATION
//  Reset asserted mid-operation returns to FETCH immediately; any partial access is abandoned.
// CONFIGURATION
//  MC_CTRL_TRAP_EN defined:
//  - ILLEGAL -> TRAP; TRAP asserts trap, pc_write, pc_source 10 for 1 cycle -> FETCH
//  - a bus_error timeout also routes to TRAP instead of FETCH
//  MC_CTRL_TRAP_EN undefined:
//  - ILLEGAL -> FETCH with no enables (NOP); trap tied to 0; pc_source never 10
// TESTING
//  1. LW, mem_ready high immediately: FETCH,DECODE,MEMADR,MEMREAD,MEMWB = 5 cycles;
//     reg_write and memory_to_reg only in cycle 5.
//  2. FETCH with mem_ready held low 3 cycles: memory_read stays 1; ir_write = pc_write = 1
//     only in cycle 4; DECODE in cycle 5.
//  3. TIMEOUT = 4, mem_ready stuck low in MEMWRITE: bus_error pulses once after 4 stall
//     cycles, memory_write drops, state_o returns to FETCH.
//  4. Opcode 1110011: DECODE -> HALT; halted = 1 and no enables for 20 cycles;
//     rst_n pulse returns to FETCH.
//  5. Opcode 1111111 with MC_CTRL_TRAP_EN: one TRAP cycle (trap = 1, pc_source = 10);
//     without the macro: FETCH follows DECODE and trap stays 0.
//  6. rst_n low during MEMREAD stall: all outputs 0 at once; FETCH after release.

Source files
------------

// File: rtl/mc_control_if.sv
// Control/handshake bundle between the multicycle control FSM and the datapath.
// master: control FSM side (consumes opcode/mem_ready, drives controls).
// slave : datapath/memory side.
// Signals: instruction_opcode, mem_ready, datapath write enables, memory port
// controls, mux selects, bus_error/halted/trap status and state_o debug.
interface mc_control_if #(
  parameter int unsigned OPC_W = 7
);
  logic [OPC_W-1:0] instruction_opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             ir_write;
  logic             pc_write_cond;
  logic             reg_write;
  logic             memory_read;
  logic             memory_write;
  logic             lorD;
  logic             memory_to_reg;
  logic             is_immediate;
  logic [1:0]       pc_source;
  logic [1:0]       aluop;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic             bus_error;
  logic             halted;
  logic             trap;
  logic [4:0]       state_o;

  modport master (
    input  instruction_opcode, mem_ready,
    output pc_write, ir_write, pc_write_cond, reg_write,
           memory_read, memory_write, lorD, memory_to_reg, is_immediate,
           pc_source, aluop, alu_src_a, alu_src_b,
           bus_error, halted, trap, state_o
  );

  modport slave (
    output instruction_opcode, mem_ready,
    input  pc_write, ir_write, pc_write_cond, reg_write,
           memory_read, memory_write, lorD, memory_to_reg, is_immediate,
           pc_source, aluop, alu_src_a, alu_src_b,
           bus_error, halted, trap, state_o
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/writeback and
// drives datapath mux selects and write enables, with a mem_ready handshake,
// stall timeout (bus_error pulse), SYSTEM halt and optional illegal-opcode trap.
// Ports: clk, rst_n (async, active-low), bus (mc_control_if.master).
// Optional feature macro: MC_CTRL_TRAP_EN (ILLEGAL and timeouts go to TRAP).
// Controls decode from state (plus mem_ready in memory states); bus_error is
// registered. state_o encoding: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4
// MEMWRITE=5 EXECR=6 EXECI=7 JAL=8 JALR_ADDR=9 JALR=10 BRANCH=11 AUIPC=12
// LUI=13 ALUWB=14 HALT=15 ILLEGAL=16 TRAP=17.
module mc_control_fsm #(
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned TIMEOUT   = 200,
  parameter int unsigned OPC_W     = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  mc_control_if.master bus
);

  localparam logic [4:0] FETCH     = 5'd0;
  localparam logic [4:0] DECODE    = 5'd1;
  localparam logic [4:0] MEMADR    = 5'd2;
  localparam logic [4:0] MEMREAD   = 5'd3;
  localparam logic [4:0] MEMWB     = 5'd4;
  localparam logic [4:0] MEMWRITE  = 5'd5;
  localparam logic [4:0] EXECR     = 5'd6;
  localparam logic [4:0] EXECI     = 5'd7;
  localparam logic [4:0] JAL       = 5'd8;
  localparam logic [4:0] JALR_ADDR = 5'd9;
  localparam logic [4:0] JALR      = 5'd10;
  localparam logic [4:0] BRANCH    = 5'd11;
  localparam logic [4:0] AUIPC     = 5'd12;
  localparam logic [4:0] LUI       = 5'd13;
  localparam logic [4:0] ALUWB     = 5'd14;
  localparam logic [4:0] HALT      = 5'd15;
  localparam logic [4:0] ILLEGAL   = 5'd16;
`ifdef MC_CTRL_TRAP_EN
  localparam logic [4:0] TRAP      = 5'd17;
  localparam logic [4:0] ABORT_TO  = TRAP;
  localparam logic [4:0] ILL_TO    = TRAP;
`else
  localparam logic [4:0] ABORT_TO  = FETCH;
  localparam logic [4:0] ILL_TO    = FETCH;
`endif

  localparam logic [OPC_W-1:0] OP_LW     = OPC_W'(7'b0000011);
  localparam logic [OPC_W-1:0] OP_SW     = OPC_W'(7'b0100011);
  localparam logic [OPC_W-1:0] OP_R      = OPC_W'(7'b0110011);
  localparam logic [OPC_W-1:0] OP_I      = OPC_W'(7'b0010011);
  localparam logic [OPC_W-1:0] OP_JAL    = OPC_W'(7'b1101111);
  localparam logic [OPC_W-1:0] OP_JALR   = OPC_W'(7'b1100111);
  localparam logic [OPC_W-1:0] OP_BRANCH = OPC_W'(7'b1100011);
  localparam logic [OPC_W-1:0] OP_AUIPC  = OPC_W'(7'b0010111);
  localparam logic [OPC_W-1:0] OP_LUI    = OPC_W'(7'b0110111);
  localparam logic [OPC_W-1:0] OP_SYSTEM = OPC_W'(7'b1110011);

  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  logic [4:0]           state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic                 bus_error_q;
  logic                 timeout_c;
  logic                 mem_state_c;
  logic [OPC_W-1:0]     opc_c;

  assign opc_c = bus.instruction_opcode;

  // State, stall counter and registered bus_error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      wait_q      <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      bus_error_q <= timeout_c;
    end
  end

  // Next state: stalls hold the state until mem_ready or timeout.
  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    timeout_c   = 1'b0;
    mem_state_c = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
    if (mem_state_c && !bus.mem_ready) begin
      // Timeout fires on the TIMEOUT-th stalled cycle; a ready cycle always wins.
      if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
        timeout_c = 1'b1;
        state_d   = ABORT_TO;
      end else begin
        wait_d = wait_q + TIMEOUT_W'(1);
      end
    end else begin
      case (state_q)
        FETCH:  state_d = DECODE;
        DECODE: begin
          if ((opc_c == OP_LW) || (opc_c == OP_SW)) state_d = MEMADR;
          else if (opc_c == OP_R)      state_d = EXECR;
          else if (opc_c == OP_I)      state_d = EXECI;
          else if (opc_c == OP_JAL)    state_d = JAL;
          else if (opc_c == OP_JALR)   state_d = JALR_ADDR;
          else if (opc_c == OP_BRANCH) state_d = BRANCH;
          else if (opc_c == OP_AUIPC)  state_d = AUIPC;
          else if (opc_c == OP_LUI)    state_d = LUI;
          else if (opc_c == OP_SYSTEM) state_d = HALT;
          else                         state_d = ILLEGAL;
        end
        MEMADR:    state_d = (opc_c == OP_SW) ? MEMWRITE : MEMREAD;
        MEMREAD:   state_d = MEMWB;
        MEMWB:     state_d = FETCH;
        MEMWRITE:  state_d = FETCH;
        EXECR:     state_d = ALUWB;
        EXECI:     state_d = ALUWB;
        JAL:       state_d = ALUWB;
        JALR_ADDR: state_d = JALR;
        JALR:      state_d = ALUWB;
        BRANCH:    state_d = FETCH;
        AUIPC:     state_d = ALUWB;
        LUI:       state_d = ALUWB;
        ALUWB:     state_d = FETCH;
        HALT:      state_d = HALT;
        ILLEGAL:   state_d = ILL_TO;
`ifdef MC_CTRL_TRAP_EN
        TRAP:      state_d = FETCH;
`endif
        default:   state_d = FETCH;
      endcase
    end
  end

  // Control decode; everything but state_o is forced low while in reset.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.reg_write     = 1'b0;
    bus.memory_read   = 1'b0;
    bus.memory_write  = 1'b0;
    bus.lorD          = 1'b0;
    bus.memory_to_reg = 1'b0;
    bus.is_immediate  = 1'b0;
    bus.pc_source     = 2'b00;
    bus.aluop         = 2'b00;
    bus.alu_src_a     = 2'b00;
    bus.alu_src_b     = 2'b00;
    bus.halted        = 1'b0;
    bus.trap          = 1'b0;
    case (state_q)
      FETCH: begin
        bus.memory_read = 1'b1;
        bus.alu_src_b   = 2'b01;
        bus.ir_write    = bus.mem_ready;
        bus.pc_write    = bus.mem_ready;
      end
      DECODE:    begin bus.alu_src_a = 2'b10; bus.alu_src_b = 2'b10; end
      MEMADR:    begin bus.alu_src_a = 2'b01; bus.alu_src_b = 2'b10; end
      MEMREAD:   begin bus.memory_read = 1'b1; bus.lorD = 1'b1; end
      MEMWB:     begin bus.reg_write = 1'b1; bus.memory_to_reg = 1'b1; end
      MEMWRITE:  begin bus.memory_write = 1'b1; bus.lorD = 1'b1; end
      EXECR: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b00;
        bus.aluop     = 2'b10;
      end
      EXECI: begin
        bus.alu_src_a    = 2'b01;
        bus.alu_src_b    = 2'b10;
        bus.aluop        = 2'b10;
        bus.is_immediate = 1'b1;
      end
      JAL, JALR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b01;
      end
      JALR_ADDR: begin bus.alu_src_a = 2'b01; bus.alu_src_b = 2'b10; end
      BRANCH: begin
        bus.alu_src_a     = 2'b01;
        bus.alu_src_b     = 2'b00;
        bus.aluop         = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
      end
      AUIPC:     begin bus.alu_src_a = 2'b10; bus.alu_src_b = 2'b10; end
      LUI:       begin bus.alu_src_a = 2'b11; bus.alu_src_b = 2'b10; end
      ALUWB:     bus.reg_write = 1'b1;
      HALT:      bus.halted = 1'b1;
`ifdef MC_CTRL_TRAP_EN
      TRAP: begin
        bus.trap      = 1'b1;
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
      end
`endif
      default: ;
    endcase
    if (!rst_n) begin
      bus.pc_write      = 1'b0;
      bus.ir_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.reg_write     = 1'b0;
      bus.memory_read   = 1'b0;
      bus.memory_write  = 1'b0;
      bus.lorD          = 1'b0;
      bus.memory_to_reg = 1'b0;
      bus.is_immediate  = 1'b0;
      bus.pc_source     = 2'b00;
      bus.aluop         = 2'b00;
      bus.alu_src_a     = 2'b00;
      bus.alu_src_b     = 2'b00;
      bus.halted        = 1'b0;
      bus.trap          = 1'b0;
    end
  end

  assign bus.bus_error = bus_error_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: a stimulus process walks each
// instruction through its phase sequence, pushing the expected state and
// control word per cycle; a negedge monitor pops and compares.
module tb_mc_control_fsm;

  localparam int unsigned TO = 4;

  localparam int P_FETCH = 0,  P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3,
                 P_MEMWB = 4,  P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7,
                 P_JAL = 8,    P_JALR_ADDR = 9, P_JALR = 10, P_BRANCH = 11,
                 P_AUIPC = 12, P_LUI = 13, P_ALUWB = 14, P_HALT = 15,
                 P_ILLEGAL = 16, P_TRAP = 17;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011,
                         OP_R = 7'b0110011, OP_I = 7'b0010011,
                         OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                         OP_BRANCH = 7'b1100011, OP_AUIPC = 7'b0010111,
                         OP_LUI = 7'b0110111, OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic       pc_write, ir_write, pc_write_cond, reg_write;
    logic       memory_read, memory_write, lorD, memory_to_reg, is_immediate;
    logic [1:0] pc_source, aluop, alu_src_a, alu_src_b;
    logic       halted, trap, bus_error;
  } ctl_t;

  typedef struct packed {
    logic [4:0] st;
    ctl_t       c;
  } exp_t;

  logic clk;
  logic rst_n;
  mc_control_if #(.OPC_W(7)) intf ();

  mc_control_fsm #(.TIMEOUT_W(8), .TIMEOUT(TO), .OPC_W(7)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (intf.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   seq[$];
  int   errors = 0;
  int   checks = 0;
  bit   berr_pend = 1'b0;

  // Control word each phase asserts, straight from the state table.
  function automatic ctl_t ctl_of(input int p, input bit mr);
    ctl_t c;
    c = '0;
    case (p)
      P_FETCH:     begin c.memory_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      P_DECODE:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b10; end
      P_MEMADR:    begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
      P_MEMREAD:   begin c.memory_read = 1; c.lorD = 1; end
      P_MEMWB:     begin c.reg_write = 1; c.memory_to_reg = 1; end
      P_MEMWRITE:  begin c.memory_write = 1; c.lorD = 1; end
      P_EXECR:     begin c.alu_src_a = 2'b01; c.aluop = 2'b10; end
      P_EXECI:     begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.aluop = 2'b10; c.is_immediate = 1; end
      P_JAL, P_JALR: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.pc_write = 1; c.pc_source = 2'b01; end
      P_JALR_ADDR: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
      P_BRANCH:    begin c.alu_src_a = 2'b01; c.aluop = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      P_AUIPC:     begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b10; end
      P_LUI:       begin c.alu_src_a = 2'b11; c.alu_src_b = 2'b10; end
      P_ALUWB:     c.reg_write = 1;
      P_HALT:      c.halted = 1;
      P_TRAP:      begin c.trap = 1; c.pc_write = 1; c.pc_source = 2'b10; end
      default:     ;
    endcase
    return c;
  endfunction

  // Phase sequence of a whole instruction, ignoring stalls.
  task automatic build_seq(input logic [6:0] opc);
    seq = {};
    seq.push_back(P_FETCH);
    seq.push_back(P_DECODE);
    case (opc)
      OP_LW:     begin seq.push_back(P_MEMADR); seq.push_back(P_MEMREAD); seq.push_back(P_MEMWB); end
      OP_SW:     begin seq.push_back(P_MEMADR); seq.push_back(P_MEMWRITE); end
      OP_R:      begin seq.push_back(P_EXECR); seq.push_back(P_ALUWB); end
      OP_I:      begin seq.push_back(P_EXECI); seq.push_back(P_ALUWB); end
      OP_JAL:    begin seq.push_back(P_JAL); seq.push_back(P_ALUWB); end
      OP_JALR:   begin seq.push_back(P_JALR_ADDR); seq.push_back(P_JALR); seq.push_back(P_ALUWB); end
      OP_BRANCH: seq.push_back(P_BRANCH);
      OP_AUIPC:  begin seq.push_back(P_AUIPC); seq.push_back(P_ALUWB); end
      OP_LUI:    begin seq.push_back(P_LUI); seq.push_back(P_ALUWB); end
      OP_SYSTEM: seq.push_back(P_HALT);
      default: begin
        seq.push_back(P_ILLEGAL);
`ifdef MC_CTRL_TRAP_EN
        seq.push_back(P_TRAP);
`endif
      end
    endcase
  endtask

  // One clock cycle: drive mem_ready, record the expectation, advance.
  task automatic cyc(input int p, input bit mr);
    exp_t e;
    intf.mem_ready = mr;
    e.st = 5'(p);
    e.c  = ctl_of(p, mr);
    e.c.bus_error = berr_pend;
    berr_pend = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // One cycle held in reset, released just after the following edge.
  task automatic rst_cyc();
    exp_t e;
    rst_n = 1'b0;
    intf.mem_ready = 1'($urandom_range(0, 1));
    e.st = 5'(P_FETCH);
    e.c  = '0;
    berr_pend = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int pick_stall();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return 0;
    if (r < 8) return int'($urandom_range(1, 2));
    return int'($urandom_range(TO - 1, TO + 1));
  endfunction

  // fk/mk: stall cycles for FETCH / data access (-1 = random).
  task automatic run_instr(input logic [6:0] opc, input int fk, input int mk, input bit rst_mem);
    int  p;
    int  k;
    bit  aborted;
    intf.instruction_opcode = opc;
    build_seq(opc);
    for (int i = 0; i < seq.size(); i++) begin
      p = seq[i];
      if (p == P_FETCH || p == P_MEMREAD || p == P_MEMWRITE) begin
        k = (p == P_FETCH) ? fk : mk;
        if (k < 0) k = pick_stall();
        if (rst_mem && p == P_MEMREAD) begin
          cyc(p, 1'b0);
          rst_cyc();
          return;
        end
        aborted = 1'b0;
        for (int j = 0; j < k && !aborted; j++) begin
          cyc(p, 1'b0);
          if (j == int'(TO) - 1) aborted = 1'b1;
        end
        if (aborted) begin
          berr_pend = 1'b1;
`ifdef MC_CTRL_TRAP_EN
          cyc(P_TRAP, 1'($urandom_range(0, 1)));
`endif
          return;
        end
        cyc(p, 1'b1);
      end else if (p == P_HALT) begin
        repeat (20) begin
          intf.instruction_opcode = 7'($urandom);
          cyc(P_HALT, 1'($urandom_range(0, 1)));
        end
        rst_cyc();
        return;
      end else begin
        cyc(p, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  // Monitor: compare every cycle the scoreboard has an expectation for.
  always @(negedge clk) begin
    exp_t e;
    ctl_t a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a.pc_write      = intf.pc_write;
      a.ir_write      = intf.ir_write;
      a.pc_write_cond = intf.pc_write_cond;
      a.reg_write     = intf.reg_write;
      a.memory_read   = intf.memory_read;
      a.memory_write  = intf.memory_write;
      a.lorD          = intf.lorD;
      a.memory_to_reg = intf.memory_to_reg;
      a.is_immediate  = intf.is_immediate;
      a.pc_source     = intf.pc_source;
      a.aluop         = intf.aluop;
      a.alu_src_a     = intf.alu_src_a;
      a.alu_src_b     = intf.alu_src_b;
      a.halted        = intf.halted;
      a.trap          = intf.trap;
      a.bus_error     = intf.bus_error;
      checks++;
      if (intf.state_o !== e.st) begin
        errors++;
        $display("FAIL state t=%0t got=%0d exp=%0d", $time, intf.state_o, e.st);
      end
      checks++;
      if (a !== e.c) begin
        errors++;
        $display("FAIL controls t=%0t state=%0d got=%h exp=%h", $time, e.st, a, e.c);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  logic [6:0] legal[9];

  initial begin
    logic [6:0] op;
    legal = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_JALR, OP_BRANCH, OP_AUIPC, OP_LUI};
    rst_n = 1'b0;
    intf.instruction_opcode = '0;
    intf.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) rst_cyc();

    run_instr(OP_LW, 0, 0, 1'b0);          // back-to-back memory ready
    run_instr(OP_LW, 3, 1, 1'b0);          // fetch stalled three cycles
    run_instr(OP_SW, 0, int'(TO), 1'b0);   // store stuck until timeout
    run_instr(OP_R, int'(TO) - 1, 0, 1'b0);// ready on the last allowed cycle
    run_instr(OP_I, int'(TO), 0, 1'b0);    // fetch timeout
    run_instr(7'b1111111, 0, 0, 1'b0);     // illegal opcode
    run_instr(OP_LW, 0, 3, 1'b1);          // reset during read stall
    for (int i = 0; i < 9; i++) run_instr(legal[i], 0, 0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      else op = legal[$urandom_range(0, 8)];
      run_instr(op, -1, -1, 1'b0);
    end

    run_instr(OP_SYSTEM, 0, 0, 1'b0);      // halt, then reset
    run_instr(OP_JALR, 0, 0, 1'b0);
    run_instr(OP_BRANCH, 1, 0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
